// File: rtl/reg_ctx_sequencer.sv
// reg_ctx_sequencer: dumps or reloads a register file context to memory,
// one word per accepted access, tolerant of arbitrary memory wait states.
module reg_ctx_sequencer #(
    parameter int WORD      = 16,
    parameter int REGISTERS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         save_req,
    input  logic                         restore_req,
    input  logic [WORD-1:0]              base_addr,
    input  logic                         mem_ready,
    input  logic [WORD-1:0]              mem_rd_data,
    input  logic [WORD-1:0]              rf_rd_data,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(REGISTERS)-1:0] rf_rd_addr,
    output logic [$clog2(REGISTERS)-1:0] rf_wr_addr,
    output logic [WORD/8-1:0]            rf_wr_en,
    output logic [WORD-1:0]              rf_wr_data,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [WORD-1:0]              mem_addr,
    output logic [WORD-1:0]              mem_wr_data
);
    localparam int IW = $clog2(REGISTERS);
    localparam int BW = WORD / 8;
    localparam logic [IW-1:0] LAST = IW'(REGISTERS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAVE,
        S_RESTORE,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [WORD-1:0] r_base;
    logic            r_busy;
    logic            r_done;
    logic            r_req;
    logic            r_we;

    logic            w_save;
    logic            w_restore;
    logic [WORD-1:0] w_addr;

    assign w_save    = (r_state == S_SAVE);
    assign w_restore = (r_state == S_RESTORE);
    // index only advances on accepted beats, so the address holds during waits
    assign w_addr    = r_base + WORD'(r_idx) * WORD'(BW);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_base  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (save_req || restore_req) begin
                        r_state <= save_req ? S_SAVE : S_RESTORE;
                        r_base  <= base_addr;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_req   <= 1'b1;
                        r_we    <= save_req;
                    end
                end
                S_SAVE, S_RESTORE: begin
                    if (mem_ready) begin
                        if (r_idx == LAST) begin
                            r_state <= S_DONE;
                            r_req   <= 1'b0;
                            r_we    <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_idx   <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign mem_req     = r_req;
    assign mem_we      = r_we;
    assign mem_addr    = r_req ? w_addr : '0;
    assign mem_wr_data = w_save ? rf_rd_data : '0;
    assign rf_rd_addr  = w_save ? r_idx : '0;
    assign rf_wr_addr  = w_restore ? r_idx : '0;
    assign rf_wr_en    = {BW{w_restore & mem_ready}};
    assign rf_wr_data  = w_restore ? mem_rd_data : '0;

endmodule
